logic_axi4_stream_demux_packet: RTL
===================================

# logic_axi4_stream_demux_packet

Packet-aware AXI4-Stream demultiplexer that routes each packet from one Rx stream to one of OUTPUTS Tx streams. The route is decided on the first beat (tdest or tid matched against MAP) and held until tlast, so packets are never split across outputs even if tdest/tid changes mid-packet. Unmatched packets go to a fall-through output or are dropped. Per-output two-entry buffers decouple `prev.tready` from every `tx[k].tready`. Sits between stream sources and per-destination consumers in the logic AXI4-Stream fabric.

## Interface
- OUTPUTS, 2, number of routed outputs (>=1)
- TDATA_BYTES, 1, tdata width in bytes; 0 disables tdata/tkeep/tstrb
- TDEST_WIDTH, 1, tdest bits
- TUSER_WIDTH, 1, tuser bits
- TID_WIDTH, 1, tid bits
- USE_TKEEP, 1, carry tkeep; else tx tkeep tied '1
- USE_TSTRB, 1, carry tstrb; else tx tstrb tied '1
- USE_TLAST, 1, packet mode; 0 = every beat is a one-beat packet, tx tlast tied '1
- USE_TID, 0, route on tid instead of tdest
- MAP_WIDTH, USE_TID ? TID_WIDTH : TDEST_WIDTH, width of one MAP entry
- MAP, identity (entry i = i), OUTPUTS entries of MAP_WIDTH; entry i selects tx[i]
- DROP_UNMATCHED, 0, 1 = discard unmatched packets, 0 = send them to `next`
- DROP_COUNT_WIDTH, 16, width of `dropped`
- aclk  input  1  clock
- areset_n  input  1  asynchronous active-low reset
- prev  rx modport  logic_axi4_stream_if  input stream
- next  tx modport  logic_axi4_stream_if  fall-through output for unmatched packets
- tx[OUTPUTS]  tx modport  logic_axi4_stream_if  routed outputs
- dropped  output  DROP_COUNT_WIDTH  saturating count of dropped packets

## Operation
- Match: select[i] = (key == MAP[i]), key = tid or tdest; multiple hits resolve to the lowest index; no hit = unmatched (to `next`, or drop when DROP_UNMATCHED=1).
- FSM per packet: IDLE, FORWARD, DROP. In IDLE the route comes from the combinational match on the current beat. On an accepted beat with tlast=0 the route is latched into route_q and the FSM enters FORWARD (matched, or unmatched with DROP_UNMATCHED=0) or DROP. In FORWARD/DROP the route comes from route_q and tdest/tid are ignored. An accepted tlast=1 beat returns to IDLE. A single-beat packet stays in IDLE.
- USE_TLAST=0: FSM stays in IDLE; every beat is routed independently.
- prev.tready = route is DROP, or the selected destination buffer is not full. It depends only on buffer state and the route, never combinationally on any tx/next tready.
- DROP: every beat is accepted and discarded. `dropped` increments on the accepted tlast beat of a dropped packet (every beat when USE_TLAST=0) and saturates at all-ones.
- Every sideband field (tdata, tkeep, tstrb, tlast, tuser, tdest, tid) passes through unchanged.
- Ordering is preserved per output. There is no ordering guarantee between different outputs.

## Timing
- Reset: all tx[k].tvalid=0, next.tvalid=0, buffers empty, FSM=IDLE, route_q=0, dropped=0. Data registers are not reset.
- Reset asserted mid-packet aborts the packet. The beats after reset are treated as a new packet whose first beat is re-matched.
- Latency: a beat accepted on prev at cycle N appears as tvalid at the destination at N+1.
- Throughput: 1 beat/cycle sustained per destination while its tready is high.
- Buffer: 2 entries (output register plus skid). Not full = fewer than 2 entries. Full with a simultaneous output pop: prev.tready stays 0 that cycle and rises the next.
- tvalid, once high, is held with stable payload until tready (AXI4-Stream rule). Outputs do not depend on the state of other outputs, so one stalled output blocks the input only while the route points at it.

## Configuration
- LOGIC_AXI4_STREAM_DEMUX_PACKET_DROP_COUNTER_EN defined: the `dropped` counter is implemented as described.
- Not defined: `dropped` is tied to '0 and no counter logic is built. Drop behaviour is otherwise identical.

## Structure
- Package logic_axi4_stream_demux_packet_pkg holds the FSM enum state_t (IDLE, FORWARD, DROP) and the route encoding constants (index OUTPUTS = fall-through, OUTPUTS+1 = drop).
- Sub-module logic_axi4_stream_demux_packet_buffer: the 2-entry skid buffer for one stream. It is instantiated OUTPUTS+1 times, once per tx output and once for `next`.

## Test plan
- Identity MAP, OUTPUTS=4: a 3-beat packet with tdest=2 -> all 3 beats on tx[2] at N+1, N+2, N+3; no other tvalid asserted.
- tdest changes 2→0 on beat 2 of a 3-beat packet -> all beats on tx[2]; the next packet with tdest=0 goes to tx[0].
- tdest=7 unmatched, DROP_UNMATCHED=0 -> packet on `next`. With DROP_UNMATCHED=1 -> prev.tready=1 every beat, no tvalid anywhere, `dropped` increments 0→1 on tlast.
- tx[1].tready=0, two beats to tx[1] -> both accepted, third beat sees prev.tready=0; a following packet to tx[0] is also blocked until tx[1] drains.
- DROP_COUNT_WIDTH=2, 5 dropped packets -> dropped reads 3 (saturated). With the macro undefined -> dropped stays 0.
- areset_n pulsed low mid-packet -> all tvalid go 0 asynchronously; the first beat after reset is routed by its own tdest.

Source files
------------

// File: rtl/logic_axi4_stream_demux_packet_pkg.sv
// Shared types and helpers for the packet demux: FSM states, route encoding, field widths, default MAP.
package logic_axi4_stream_demux_packet_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FORWARD = 2'd1,
    DROP    = 2'd2
  } state_t;

  // Upper bound on the packed MAP parameter; entries beyond OUTPUTS*MAP_WIDTH are ignored.
  localparam int MAP_MAX = 256;

  // Route index 0..OUTPUTS-1 selects tx[i]; OUTPUTS is the fall-through, OUTPUTS+1 is drop.
  function automatic int route_fall(input int outputs);
    return outputs;
  endfunction

  function automatic int route_drop(input int outputs);
    return outputs + 1;
  endfunction

  function automatic int route_width(input int outputs);
    return $clog2(outputs + 2);
  endfunction

  // A zero-byte stream still carries a one-byte dummy lane so no vector collapses to zero width.
  function automatic int data_width(input int bytes);
    return (bytes > 0) ? bytes * 8 : 8;
  endfunction

  function automatic int keep_width(input int bytes);
    return (bytes > 0) ? bytes : 1;
  endfunction

  function automatic logic [MAP_MAX-1:0] identity_map(input int outputs, input int width);
    logic [MAP_MAX-1:0] m;
    logic [MAP_MAX-1:0] mask;
    m    = '0;
    mask = (MAP_MAX'(1) << width) - MAP_MAX'(1);
    for (int i = 0; i < outputs; i++) begin
      m = m | ((MAP_MAX'(i) & mask) << (i * width));
    end
    return m;
  endfunction

endpackage

// File: rtl/logic_axi4_stream_if.sv
// AXI4-Stream bundle with tx (source) and rx (sink) modports; zero-byte tdata keeps a dummy byte lane.
interface logic_axi4_stream_if #(
  parameter int TDATA_BYTES = 1,
  parameter int TDEST_WIDTH = 1,
  parameter int TUSER_WIDTH = 1,
  parameter int TID_WIDTH   = 1
);
  localparam int DATA_W = (TDATA_BYTES > 0) ? TDATA_BYTES * 8 : 8;
  localparam int KEEP_W = (TDATA_BYTES > 0) ? TDATA_BYTES : 1;

  logic                   tvalid;
  logic                   tready;
  logic [DATA_W-1:0]      tdata;
  logic [KEEP_W-1:0]      tkeep;
  logic [KEEP_W-1:0]      tstrb;
  logic                   tlast;
  logic [TUSER_WIDTH-1:0] tuser;
  logic [TDEST_WIDTH-1:0] tdest;
  logic [TID_WIDTH-1:0]   tid;

  modport tx (output tvalid, tdata, tkeep, tstrb, tlast, tuser, tdest, tid, input tready);
  modport rx (input tvalid, tdata, tkeep, tstrb, tlast, tuser, tdest, tid, output tready);
endinterface

// File: rtl/logic_axi4_stream_demux_packet_buffer.sv
// Two-entry output buffer (output register plus skid) for one demux destination.
module logic_axi4_stream_demux_packet_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk_sys,
  input  logic             rst_b,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_payload,
  output logic             full,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_payload
);

  logic [1:0]       count;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] skid_q;
  logic             push;
  logic             pop;

  // Full ignores a same-cycle pop so the upstream ready never sees downstream tready.
  assign full        = (count == 2'd2);
  assign out_valid   = (count != 2'd0);
  assign out_payload = head_q;
  assign pop         = out_valid && out_ready;
  assign push        = in_valid && !full;

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      count <= 2'd0;
    end else begin
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk_sys) begin
    if ((count == 2'd0) || ((count == 2'd1) && pop)) begin
      if (push) head_q <= in_payload;
    end else if (count == 2'd1) begin
      if (push) skid_q <= in_payload;
    end else if (pop) begin
      head_q <= skid_q;
    end
  end

endmodule

// File: rtl/logic_axi4_stream_demux_packet.sv
// Packet-aware AXI4-Stream demux: route fixed on the first beat, held to tlast, buffered per output.
// Define LOGIC_AXI4_STREAM_DEMUX_PACKET_DROP_COUNTER_EN to build the saturating `dropped` counter.
//
// state   | meaning
// IDLE    | between packets; route comes from matching the current beat's key
// FORWARD | mid-packet; beats follow route_q to a tx output or the fall-through
// DROP    | mid-packet; beats are accepted and discarded
module logic_axi4_stream_demux_packet
  import logic_axi4_stream_demux_packet_pkg::*;
#(
  parameter int                 OUTPUTS          = 2,
  parameter int                 TDATA_BYTES      = 1,
  parameter int                 TDEST_WIDTH      = 1,
  parameter int                 TUSER_WIDTH      = 1,
  parameter int                 TID_WIDTH        = 1,
  parameter bit                 USE_TKEEP        = 1'b1,
  parameter bit                 USE_TSTRB        = 1'b1,
  parameter bit                 USE_TLAST        = 1'b1,
  parameter bit                 USE_TID          = 1'b0,
  parameter int                 MAP_WIDTH        = USE_TID ? TID_WIDTH : TDEST_WIDTH,
  parameter logic [MAP_MAX-1:0] MAP              = identity_map(OUTPUTS, MAP_WIDTH),
  parameter bit                 DROP_UNMATCHED   = 1'b0,
  parameter int                 DROP_COUNT_WIDTH = 16
) (
  input  logic                        aclk,
  input  logic                        areset_n,
  logic_axi4_stream_if.rx             prev,
  logic_axi4_stream_if.tx             next,
  logic_axi4_stream_if.tx             tx [OUTPUTS],
  output logic [DROP_COUNT_WIDTH-1:0] dropped
);

  localparam int RW     = route_width(OUTPUTS);
  localparam int DATA_W = data_width(TDATA_BYTES);
  localparam int KEEP_W = keep_width(TDATA_BYTES);
  localparam int PW     = DATA_W + 2 * KEEP_W + 1 + TUSER_WIDTH + TDEST_WIDTH + TID_WIDTH;
  localparam logic [RW-1:0] R_FALL = RW'(route_fall(OUTPUTS));
  localparam logic [RW-1:0] R_DROP = RW'(route_drop(OUTPUTS));

  state_t           state;
  logic [RW-1:0]    route_q;
  logic [RW-1:0]    match_route;
  logic [RW-1:0]    route;
  logic [MAP_WIDTH-1:0] key;
  logic             ready;
  logic             accept;
  logic             beat_last;
  logic [OUTPUTS:0] push;
  logic [OUTPUTS:0] buf_full;

  logic [DATA_W-1:0] in_data;
  logic [KEEP_W-1:0] in_keep;
  logic [KEEP_W-1:0] in_strb;
  logic [PW-1:0]     pl_in;

  if (USE_TID) begin : g_key_tid
    assign key = prev.tid;
  end else begin : g_key_tdest
    assign key = prev.tdest;
  end

  // Descending scan so the lowest matching index is the one that sticks.
  always_comb begin
    match_route = DROP_UNMATCHED ? R_DROP : R_FALL;
    for (int i = OUTPUTS - 1; i >= 0; i--) begin
      if (key == MAP[i*MAP_WIDTH +: MAP_WIDTH]) match_route = RW'(i);
    end
  end

  assign route = (state == IDLE) ? match_route : route_q;

  always_comb begin
    ready = 1'b1;
    for (int k = 0; k <= OUTPUTS; k++) begin
      if (route == RW'(k)) ready = !buf_full[k];
    end
  end

  assign prev.tready = ready;
  assign accept      = prev.tvalid && ready;
  assign beat_last   = USE_TLAST ? prev.tlast : 1'b1;

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state   <= IDLE;
      route_q <= '0;
    end else if (accept) begin
      if (beat_last) begin
        state <= IDLE;
      end else if (state == IDLE) begin
        route_q <= match_route;
        state   <= (match_route == R_DROP) ? DROP : FORWARD;
      end
    end
  end

  // Disabled sideband fields are replaced before buffering so every output sees the tie-off value.
  assign in_data = (TDATA_BYTES > 0) ? prev.tdata : '0;
  assign in_keep = (USE_TKEEP && (TDATA_BYTES > 0)) ? prev.tkeep : '1;
  assign in_strb = (USE_TSTRB && (TDATA_BYTES > 0)) ? prev.tstrb : '1;
  assign pl_in   = {in_data, in_keep, in_strb, beat_last, prev.tuser, prev.tdest, prev.tid};

  for (genvar k = 0; k <= OUTPUTS; k++) begin : g_push
    assign push[k] = accept && (route == RW'(k));
  end

  for (genvar k = 0; k < OUTPUTS; k++) begin : g_tx
    logic          vld;
    logic [PW-1:0] pl_out;

    logic_axi4_stream_demux_packet_buffer #(.WIDTH(PW)) u_buf (
      .clk_sys     (aclk),
      .rst_b       (areset_n),
      .in_valid    (push[k]),
      .in_payload  (pl_in),
      .full        (buf_full[k]),
      .out_valid   (vld),
      .out_ready   (tx[k].tready),
      .out_payload (pl_out)
    );

    assign tx[k].tvalid = vld;
    assign {tx[k].tdata, tx[k].tkeep, tx[k].tstrb, tx[k].tlast,
            tx[k].tuser, tx[k].tdest, tx[k].tid} = pl_out;
  end

  logic          next_vld;
  logic [PW-1:0] next_pl;

  logic_axi4_stream_demux_packet_buffer #(.WIDTH(PW)) u_buf_next (
    .clk_sys     (aclk),
    .rst_b       (areset_n),
    .in_valid    (push[OUTPUTS]),
    .in_payload  (pl_in),
    .full        (buf_full[OUTPUTS]),
    .out_valid   (next_vld),
    .out_ready   (next.tready),
    .out_payload (next_pl)
  );

  assign next.tvalid = next_vld;
  assign {next.tdata, next.tkeep, next.tstrb, next.tlast,
          next.tuser, next.tdest, next.tid} = next_pl;

`ifdef LOGIC_AXI4_STREAM_DEMUX_PACKET_DROP_COUNTER_EN
  logic [DROP_COUNT_WIDTH-1:0] dropped_q;

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      dropped_q <= '0;
    end else if (accept && beat_last && (route == R_DROP) && (dropped_q != '1)) begin
      dropped_q <= dropped_q + 1'b1;
    end
  end

  assign dropped = dropped_q;
`else
  assign dropped = '0;
`endif

endmodule
